// File: rtl/tpu_pkg.sv
// Shared types and defaults for the TPU tile sequencer: FSM state encoding,
// default array geometry, and the drain-length rule.
package tpu_pkg;

   localparam int unsigned DEF_DEPTH     = 4;
   localparam int unsigned DEF_BIT_WIDTH = 8;
   localparam int unsigned DEF_ACC_WIDTH = 32;
   localparam int unsigned DEF_TILE_LEN  = 8;
   localparam int unsigned DEF_BASE_LAT  = 5;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN
   } seq_state_e;

   // Covers the row skew in, array latency, and column skew out for the last beat.
   function automatic int unsigned drain_cycles(input int unsigned depth,
                                                input int unsigned base_lat);
      return (depth - 1) + base_lat + (depth - 1) + 1;
   endfunction

   localparam int unsigned DRAIN_CYC = drain_cycles(DEF_DEPTH, DEF_BASE_LAT);

endpackage

// File: rtl/tpu_tile_sequencer_skew_line.sv
// Zero-reset shift register of LEN stages; used for per-row data skew and the
// valid-tag pipe feeding col_valid.
module skew_line #(
   parameter int unsigned W   = 8,
   parameter int unsigned LEN = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage [LEN];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < LEN; k++) stage[k] <= '0;
      end else begin
         stage[0] <= din;
         for (int unsigned k = 1; k < LEN; k++) stage[k] <= stage[k-1];
      end
   end

   assign dout = stage[LEN-1];

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Feeds one weight tile and TILE_LEN skewed activation vectors into a
// weight-stationary systolic array, and tags which result columns are valid.
module tpu_tile_sequencer
   import tpu_pkg::*;
#(
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int unsigned TILE_LEN  = DEF_TILE_LEN,
   parameter int unsigned BASE_LAT  = DEF_BASE_LAT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   input  logic                       wt_valid,
   output logic                       wt_ready,
   input  logic [BIT_WIDTH*DEPTH-1:0] wt_row,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BIT_WIDTH*DEPTH-1:0] in_vec,
   output logic                       control,
   output logic [BIT_WIDTH*DEPTH-1:0] wt_arr,
   output logic [BIT_WIDTH*DEPTH-1:0] data_arr,
   output logic [DEPTH-1:0]           col_valid
);

   localparam int unsigned DRAIN_N = drain_cycles(DEPTH, BASE_LAT);
   localparam int unsigned RW      = $clog2(DEPTH + 1);
   localparam int unsigned VW      = $clog2(TILE_LEN + 1);
   localparam int unsigned DW      = $clog2(DRAIN_N + 1);

   localparam logic [RW-1:0] ROW_LAST   = RW'(DEPTH - 1);
   localparam logic [VW-1:0] VEC_LAST   = VW'(TILE_LEN - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_N - 1);

   seq_state_e    state, state_next;
   logic [RW-1:0] row_cnt, row_cnt_next;
   logic [VW-1:0] vec_cnt, vec_cnt_next;
   logic [DW-1:0] drain_cnt, drain_cnt_next;
   logic          wt_acc, in_acc;

   assign wt_ready = (state == LOAD_W);
   assign in_ready = (state == STREAM);
   assign wt_acc   = wt_valid & wt_ready;
   assign in_acc   = in_valid & in_ready;

   always_comb begin
      state_next     = state;
      row_cnt_next   = row_cnt;
      vec_cnt_next   = vec_cnt;
      drain_cnt_next = drain_cnt;
      unique case (state)
         IDLE:   if (start) state_next = LOAD_W;
         LOAD_W: if (wt_acc) begin
                    if (row_cnt == ROW_LAST) state_next = STREAM;
                    else                     row_cnt_next = row_cnt + RW'(1);
                 end
         STREAM: if (in_acc) begin
                    if (vec_cnt == VEC_LAST) state_next = DRAIN;
                    else                     vec_cnt_next = vec_cnt + VW'(1);
                 end
         DRAIN:  if (drain_cnt == DRAIN_LAST) state_next = IDLE;
                 else                         drain_cnt_next = drain_cnt + DW'(1);
         default: state_next = IDLE;
      endcase
      if (state_next != state) begin
         row_cnt_next   = '0;
         vec_cnt_next   = '0;
         drain_cnt_next = '0;
      end
   end

   // Registered outputs are computed from next-state so they line up with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         row_cnt   <= '0;
         vec_cnt   <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         control   <= 1'b0;
         wt_arr    <= '0;
      end else begin
         state     <= state_next;
         row_cnt   <= row_cnt_next;
         vec_cnt   <= vec_cnt_next;
         drain_cnt <= drain_cnt_next;
         busy      <= (state_next != IDLE);
         done      <= (state_next == DRAIN) && (drain_cnt_next == DRAIN_LAST);
         control   <= wt_acc;
         wt_arr    <= wt_acc ? wt_row : '0;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_row
      logic [BIT_WIDTH-1:0] row_in;
      assign row_in = in_acc ? in_vec[g*BIT_WIDTH +: BIT_WIDTH] : '0;

      skew_line #(.W(BIT_WIDTH), .LEN(g + 1)) u_data (
         .clk  (clk),
         .reset(reset),
         .din  (row_in),
         .dout (data_arr[g*BIT_WIDTH +: BIT_WIDTH])
      );

      skew_line #(.W(1), .LEN(BASE_LAT + 1 + g)) u_tag (
         .clk  (clk),
         .reset(reset),
         .din  (in_acc),
         .dout (col_valid[g])
      );
   end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Randomized scoreboard bench: the stimulus side predicts timed output events
// from the tile rules; a negedge monitor pops and compares them every cycle.
module tb_tpu_tile_sequencer;

   localparam int DEPTH     = 4;
   localparam int BW        = 8;
   localparam int TILE_LEN  = 8;
   localparam int BASE_LAT  = 5;
   localparam int DRAIN_CYC = (DEPTH - 1) + BASE_LAT + (DEPTH - 1) + 1;
   localparam int VW        = BW * DEPTH;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, wt_ready, in_ready, control;
   logic          wt_valid = 1'b0;
   logic          in_valid = 1'b0;
   logic [VW-1:0] wt_row = '0;
   logic [VW-1:0] in_vec = '0;
   logic [VW-1:0] wt_arr, data_arr;
   logic [DEPTH-1:0] col_valid;

   tpu_tile_sequencer #(
      .DEPTH(DEPTH), .BIT_WIDTH(BW), .TILE_LEN(TILE_LEN), .BASE_LAT(BASE_LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_row(wt_row),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .control(control), .wt_arr(wt_arr), .data_arr(data_arr), .col_valid(col_valid)
   );

   always #5 clk = ~clk;

   typedef enum {PH_IDLE, PH_LOAD, PH_STREAM, PH_DRAIN} ph_t;
   typedef struct {int cyc; logic [31:0] val;} exp_t;

   ph_t  ph = PH_IDLE;
   int   cyc = 0;
   int   rows = 0, vecs = 0, drain_end = 0;
   bit   chk_en = 1'b0;
   int   n_pass = 0, n_total = 0;

   exp_t wt_q[$];
   exp_t data_q[DEPTH][$];
   int   cv_q[DEPTH][$];
   int   done_q[$];

   function automatic void check(input string name, input logic [63:0] got,
                                 input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
   endfunction

   // Expected-event monitor: each cycle either the head event is due now or the output is idle.
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         check("busy", busy, ph != PH_IDLE);
         check("wt_ready", wt_ready, ph == PH_LOAD);
         check("in_ready", in_ready, ph == PH_STREAM);
         if (wt_q.size() > 0 && wt_q[0].cyc == cyc) begin
            check("control", control, 1'b1);
            check("wt_arr", wt_arr, wt_q[0].val);
            void'(wt_q.pop_front());
         end else begin
            check("control", control, 1'b0);
            check("wt_arr", wt_arr, '0);
         end
         for (int r = 0; r < DEPTH; r++) begin
            if (data_q[r].size() > 0 && data_q[r][0].cyc == cyc) begin
               check($sformatf("data_row%0d", r), data_arr[r*BW +: BW], data_q[r][0].val);
               void'(data_q[r].pop_front());
            end else begin
               check($sformatf("data_row%0d_idle", r), data_arr[r*BW +: BW], '0);
            end
         end
         for (int c = 0; c < DEPTH; c++) begin
            if (cv_q[c].size() > 0 && cv_q[c][0] == cyc) begin
               check($sformatf("col_valid%0d", c), col_valid[c], 1'b1);
               void'(cv_q[c].pop_front());
            end else begin
               check($sformatf("col_valid%0d_idle", c), col_valid[c], 1'b0);
            end
         end
         if (done_q.size() > 0 && done_q[0] == cyc) begin
            check("done", done, 1'b1);
            void'(done_q.pop_front());
         end else begin
            check("done_idle", done, 1'b0);
         end
      end
   end

   task automatic tick();
      bit            wacc, iacc, st;
      logic [VW-1:0] wr, iv;
      wacc = (ph == PH_LOAD) && wt_valid;
      iacc = (ph == PH_STREAM) && in_valid;
      st   = (ph == PH_IDLE) && start;
      wr   = wt_row;
      iv   = in_vec;
      @(posedge clk);
      cyc++;
      if (wacc) begin
         wt_q.push_back('{cyc, wr});
         rows++;
         if (rows == DEPTH) begin ph = PH_STREAM; vecs = 0; end
      end
      if (iacc) begin
         for (int i = 0; i < DEPTH; i++) data_q[i].push_back('{cyc + i, 32'(iv[i*BW +: BW])});
         for (int c = 0; c < DEPTH; c++) cv_q[c].push_back(cyc + BASE_LAT + c);
         vecs++;
         if (vecs == TILE_LEN) begin
            ph = PH_DRAIN;
            done_q.push_back(cyc + DRAIN_CYC - 1);
            drain_end = cyc + DRAIN_CYC;
         end
      end
      if (st) begin
         ph = PH_LOAD;
         rows = 0;
      end else if (ph == PH_DRAIN && cyc == drain_end) begin
         ph = PH_IDLE;
      end
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      start  = 1'b1;
      chk_en = 1'b0;
      ph     = PH_IDLE;
      wt_q.delete();
      done_q.delete();
      for (int r = 0; r < DEPTH; r++) begin data_q[r].delete(); cv_q[r].delete(); end
      #1;
      check("rst_flags", {busy, done, wt_ready, in_ready, control, col_valid}, '0);
      check("rst_wt_arr", wt_arr, '0);
      check("rst_data_arr", data_arr, '0);
      @(posedge clk); cyc++;
      @(posedge clk); cyc++;
      #1;
      check("rst_hold_flags", {busy, done, wt_ready, in_ready, control, col_valid}, '0);
      check("rst_hold_data", data_arr, '0);
      start  = 1'b0;
      reset  = 1'b0;
      chk_en = 1'b1;
   endtask

   // wmode: 0 always valid, 1 valid dropped for 3 load cycles, 2 random.
   // imode: 0 alternating 1,0,1..., 1 random. abort_at >= 0 resets after that many vectors.
   task automatic run_tile(input bit fixed, input int wmode, input int imode, input int abort_at);
      logic [VW-1:0] rowtab [DEPTH];
      int ld_n, st_n, guard;
      rowtab[0] = 32'h04030201;
      rowtab[1] = 32'h07060504;
      rowtab[2] = 32'h0A090807;
      rowtab[3] = 32'h0D0C0B0A;
      start = 1'b1;
      tick();
      start = 1'b0;
      ld_n = 0; st_n = 0; guard = 0;
      while (ph != PH_IDLE && guard < 300) begin
         case (wmode)
            0:       wt_valid = 1'b1;
            1:       wt_valid = !(ph == PH_LOAD && ld_n >= 1 && ld_n <= 3);
            default: wt_valid = 1'($urandom_range(0, 1));
         endcase
         wt_row = (fixed && ph == PH_LOAD) ? rowtab[rows] : VW'($urandom);
         if (imode == 0) in_valid = (st_n % 2 == 0);
         else            in_valid = ($urandom_range(0, 3) != 0);
         in_vec = (fixed && ph == PH_STREAM && vecs == 0) ? 32'h04030201 : VW'($urandom);
         start  = (ph == PH_STREAM && st_n == 2) ? 1'b1 : ($urandom_range(0, 7) == 0);
         if (ph == PH_LOAD)   ld_n++;
         if (ph == PH_STREAM) st_n++;
         tick();
         guard++;
         if (abort_at >= 0 && ph == PH_STREAM && vecs == abort_at) begin
            do_reset();
            guard = 0;
            break;
         end
      end
      check("tile_completes_in_budget", guard >= 300, 1'b0);
      start = 1'b0; wt_valid = 1'b0; in_valid = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #2;
      do_reset();
      tick();
      run_tile(1'b1, 0, 0, -1);
      run_tile(1'b0, 1, 1, -1);
      run_tile(1'b0, 2, 1, 3);
      run_tile(1'b0, 2, 1, -1);
      repeat (4) run_tile(1'b0, 2, 1, -1);
      run_tile(1'b0, 0, 0, -1);
      check("wt_q_drained", wt_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);
      for (int r = 0; r < DEPTH; r++) begin
         check($sformatf("data_q%0d_drained", r), data_q[r].size(), 0);
         check($sformatf("cv_q%0d_drained", r), cv_q[r].size(), 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
